frame_request_arbiter: RTL and testbench

Parametrised frame-request arbiter for the CMOS capture path. It selects one of `N_CH` request sources: channel 0 is the autonomous SD-card store path, and channels 1..N_CH-1 are host/USB-style on-demand paths. It issues a one-cycle `frame_trigger` to the sensor front end and a one-cycle `write_start` to the DDR3 writer once the blanking period (`black_output`) follows a trigger. It adds deferred channel switching, a frame watchdog and a frame counter.

---
 rtl/frame_request_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_frame_request_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_request_arbiter.sv
// Frame-request arbiter for the CMOS capture path: picks one of N_CH request sources,
// issues sensor frame triggers and DDR3 write starts, with deferred switching and a watchdog.
module frame_request_arbiter #(
    parameter int unsigned N_CH        = 32'd4,
    parameter int unsigned CH_W        = 32'd2,
    parameter int unsigned SYNC_STAGES = 32'd2,
    parameter int unsigned TIMEOUT     = 24'd12_000_000,
    parameter int unsigned TO_W        = 32'd24,
    parameter int unsigned FCNT_W      = 32'd16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              initial_done,
    input  logic              write_frame_done,
    input  logic              black_output,
    input  logic [N_CH-1:0]   sel_req,
    input  logic [N_CH-1:0]   frame_req,
    input  logic [N_CH-1:0]   data_req,
    output logic              frame_trigger,
    output logic              write_start,
    output logic              request_data,
    output logic [CH_W-1:0]   active_ch,
    output logic [FCNT_W-1:0] frame_count,
    output logic              timeout_err
);

    typedef enum logic [1:0] {
        ST_WAIT_INIT = 2'd0,
        ST_IDLE      = 2'd1,
        ST_BUSY      = 2'd2
    } state_t;

    localparam logic [TO_W-1:0]   WD_LAST  = TO_W'(TIMEOUT - 32'd1);
    localparam logic [TO_W-1:0]   WD_ONE   = TO_W'(32'd1);
    localparam logic [FCNT_W-1:0] FCNT_ONE = FCNT_W'(32'd1);

    function automatic logic [CH_W-1:0] lowest_set(input logic [N_CH-1:0] v);
        logic [CH_W-1:0] idx;
        logic            found;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < int'(N_CH); i++) begin
            if (v[i] && !found) begin
                idx   = CH_W'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    state_t                 state_r;
    logic [CH_W-1:0]        active_ch_r;
    logic [CH_W-1:0]        pend_ch_r;
    logic                   pend_vld_r;
    logic [TO_W-1:0]        wd_r;
    logic [FCNT_W-1:0]      frame_count_r;
    logic                   frame_trigger_r;
    logic                   timeout_err_r;
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_last_r;
    logic                   init_rise_r;
    logic                   armed_r;
    logic                   armed_d1_r;
    logic                   armed_d2_r;
    logic                   write_start_r;
    logic                   request_data_r;

    logic                   sel_vld_s;
    logic [CH_W-1:0]        sel_idx_s;
    logic                   pend_vld_s;
    logic [CH_W-1:0]        pend_ch_s;
    logic                   wd_hit_s;

    // Decode the incoming selection and merge it with any stored pending switch.
    always_comb begin
        sel_vld_s = |sel_req;
        sel_idx_s = lowest_set(sel_req);
        wd_hit_s  = (wd_r == WD_LAST);
        if (sel_vld_s) begin
            pend_vld_s = 1'b1;
            pend_ch_s  = sel_idx_s;
        end else begin
            pend_vld_s = pend_vld_r;
            pend_ch_s  = pend_ch_r;
        end
    end

    // Synchronise initial_done and register its rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r      <= '0;
            sync_last_r <= 1'b0;
            init_rise_r <= 1'b0;
        end else begin
            sync_r      <= {sync_r[SYNC_STAGES-2:0], initial_done};
            sync_last_r <= sync_r[SYNC_STAGES-1];
            init_rise_r <= sync_r[SYNC_STAGES-1] & ~sync_last_r;
        end
    end

    // Frame FSM with channel ownership, watchdog, frame counter and one-cycle pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= ST_WAIT_INIT;
            active_ch_r     <= '0;
            pend_ch_r       <= '0;
            pend_vld_r      <= 1'b0;
            wd_r            <= '0;
            frame_count_r   <= '0;
            frame_trigger_r <= 1'b0;
            timeout_err_r   <= 1'b0;
        end else begin
            frame_trigger_r <= 1'b0;
            timeout_err_r   <= 1'b0;
            case (state_r)
                ST_WAIT_INIT: begin
                    if (sel_vld_s) begin
                        active_ch_r <= sel_idx_s;
                    end
                    if (active_ch_r != '0) begin
                        state_r <= ST_IDLE;
                    end else if (init_rise_r) begin
                        frame_trigger_r <= 1'b1;
                        frame_count_r   <= frame_count_r + FCNT_ONE;
                        wd_r            <= '0;
                        state_r         <= ST_BUSY;
                    end
                end
                ST_IDLE: begin
                    if (sel_vld_s) begin
                        active_ch_r <= sel_idx_s;
                    end
                    // Channel 0 free-runs; on-demand channels wait for their own request.
                    if ((active_ch_r == '0) || frame_req[active_ch_r]) begin
                        frame_trigger_r <= 1'b1;
                        frame_count_r   <= frame_count_r + FCNT_ONE;
                        wd_r            <= '0;
                        state_r         <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (write_frame_done || wd_hit_s) begin
                        timeout_err_r <= wd_hit_s & ~write_frame_done;
                        if ((active_ch_r == '0) && !pend_vld_s) begin
                            frame_trigger_r <= 1'b1;
                            frame_count_r   <= frame_count_r + FCNT_ONE;
                            wd_r            <= '0;
                        end else begin
                            state_r    <= ST_IDLE;
                            wd_r       <= '0;
                            pend_vld_r <= 1'b0;
                            if (pend_vld_s) begin
                                active_ch_r <= pend_ch_s;
                            end
                        end
                    end else begin
                        wd_r <= wd_r + WD_ONE;
                        if (sel_vld_s) begin
                            pend_ch_r  <= sel_idx_s;
                            pend_vld_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r    <= ST_WAIT_INIT;
                    wd_r       <= '0;
                    pend_vld_r <= 1'b0;
                end
            endcase
        end
    end

    // Arm on blanking after a trigger; write_start is the delayed rising edge of armed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_r       <= 1'b0;
            armed_d1_r    <= 1'b0;
            armed_d2_r    <= 1'b0;
            write_start_r <= 1'b0;
        end else begin
            if (frame_trigger_r) begin
                armed_r <= 1'b0;
            end else if (black_output) begin
                armed_r <= 1'b1;
            end
            armed_d1_r    <= armed_r;
            armed_d2_r    <= armed_d1_r;
            write_start_r <= armed_d1_r & ~armed_d2_r;
        end
    end

    // Readout data request of the owning channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            request_data_r <= 1'b0;
        end else begin
            request_data_r <= data_req[active_ch_r];
        end
    end

    assign frame_trigger = frame_trigger_r;
    assign write_start   = write_start_r;
    assign request_data  = request_data_r;
    assign active_ch     = active_ch_r;
    assign frame_count   = frame_count_r;
    assign timeout_err   = timeout_err_r;

endmodule

// File: tb/tb_frame_request_arbiter.sv
// Directed testbench for frame_request_arbiter (N_CH=4, SYNC_STAGES=2, TIMEOUT=100).
module tb_frame_request_arbiter;

    logic        clk;
    logic        rst_n;
    logic        initial_done;
    logic        write_frame_done;
    logic        black_output;
    logic [3:0]  sel_req;
    logic [3:0]  frame_req;
    logic [3:0]  data_req;
    logic        frame_trigger;
    logic        write_start;
    logic        request_data;
    logic [1:0]  active_ch;
    logic [15:0] frame_count;
    logic        timeout_err;

    int vec_cnt;
    int miss_cnt;
    int hits_a;
    int hits_b;

    frame_request_arbiter #(
        .N_CH(4), .CH_W(2), .SYNC_STAGES(2), .TIMEOUT(100), .TO_W(24), .FCNT_W(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .initial_done(initial_done),
        .write_frame_done(write_frame_done),
        .black_output(black_output),
        .sel_req(sel_req),
        .frame_req(frame_req),
        .data_req(data_req),
        .frame_trigger(frame_trigger),
        .write_start(write_start),
        .request_data(request_data),
        .active_ch(active_ch),
        .frame_count(frame_count),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            miss_cnt++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ft"}, 32'(frame_trigger), 32'd0);
        chk({tag, "_ws"}, 32'(write_start), 32'd0);
        chk({tag, "_rd"}, 32'(request_data), 32'd0);
        chk({tag, "_ch"}, 32'(active_ch), 32'd0);
        chk({tag, "_cnt"}, 32'(frame_count), 32'd0);
        chk({tag, "_te"}, 32'(timeout_err), 32'd0);
    endtask

    initial begin
        vec_cnt = 0;
        miss_cnt = 0;
        rst_n = 1'b0;
        initial_done = 1'b0;
        write_frame_done = 1'b0;
        black_output = 1'b0;
        sel_req = 4'b0000;
        frame_req = 4'b0000;
        data_req = 4'b0000;

        // Reset state
        repeat (3) tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();
        tick();
        chk("idle_after_reset_ft", 32'(frame_trigger), 32'd0);

        // initial_done rise -> trigger four cycles later
        initial_done = 1'b1;
        tick();
        tick();
        tick();
        chk("init_ft_early", 32'(frame_trigger), 32'd0);
        tick();
        chk("init_ft", 32'(frame_trigger), 32'd1);
        chk("init_cnt", 32'(frame_count), 32'd1);
        chk("init_ch", 32'(active_ch), 32'd0);
        tick();
        chk("init_ft_width", 32'(frame_trigger), 32'd0);

        // black_output held for 10 cycles -> one write_start at t+3
        black_output = 1'b1;
        tick();
        chk("ws_t1", 32'(write_start), 32'd0);
        tick();
        chk("ws_t2", 32'(write_start), 32'd0);
        tick();
        chk("ws_t3", 32'(write_start), 32'd1);
        hits_a = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (write_start) hits_a++;
        end
        chk("ws_held_extra", 32'(hits_a), 32'd0);
        black_output = 1'b0;

        // write_frame_done on ch0 -> re-trigger one cycle later
        write_frame_done = 1'b1;
        tick();
        write_frame_done = 1'b0;
        chk("retrig_ft", 32'(frame_trigger), 32'd1);
        chk("retrig_cnt", 32'(frame_count), 32'd2);
        tick();
        chk("retrig_ft_width", 32'(frame_trigger), 32'd0);

        // Second arm after the new trigger -> second write_start
        black_output = 1'b1;
        tick();
        black_output = 1'b0;
        chk("ws2_t1", 32'(write_start), 32'd0);
        tick();
        chk("ws2_t2", 32'(write_start), 32'd0);
        tick();
        chk("ws2_t3", 32'(write_start), 32'd1);
        tick();
        chk("ws2_width", 32'(write_start), 32'd0);

        // Deferred switch while BUSY on ch0
        sel_req = 4'b0100;
        tick();
        chk("defer_ch_a", 32'(active_ch), 32'd0);
        sel_req = 4'b1000;
        tick();
        sel_req = 4'b0000;
        chk("defer_ch_b", 32'(active_ch), 32'd0);
        tick();
        tick();
        chk("defer_ch_c", 32'(active_ch), 32'd0);
        write_frame_done = 1'b1;
        tick();
        write_frame_done = 1'b0;
        chk("switch_ch", 32'(active_ch), 32'd3);
        chk("switch_no_retrig", 32'(frame_trigger), 32'd0);
        tick();
        chk("switch_idle_ft", 32'(frame_trigger), 32'd0);

        // frame_req from a non-active channel is ignored, the owner's is served
        frame_req = 4'b0100;
        tick();
        frame_req = 4'b0000;
        chk("fr_other_a", 32'(frame_trigger), 32'd0);
        tick();
        chk("fr_other_b", 32'(frame_trigger), 32'd0);
        frame_req = 4'b1000;
        tick();
        frame_req = 4'b0000;
        chk("fr_owner_ft", 32'(frame_trigger), 32'd1);
        chk("fr_owner_cnt", 32'(frame_count), 32'd3);
        tick();
        chk("fr_owner_width", 32'(frame_trigger), 32'd0);
        write_frame_done = 1'b1;
        tick();
        write_frame_done = 1'b0;
        chk("ch3_done_ft", 32'(frame_trigger), 32'd0);
        tick();
        chk("ch3_idle_ft", 32'(frame_trigger), 32'd0);

        // sel_req=0110 in IDLE -> ch1; request_data lags data_req[1] by one cycle
        sel_req = 4'b0110;
        tick();
        sel_req = 4'b0000;
        chk("sel_low_bit", 32'(active_ch), 32'd1);
        data_req = 4'b0010;
        #1;
        chk("rd_lag_0", 32'(request_data), 32'd0);
        tick();
        chk("rd_follow_1", 32'(request_data), 32'd1);
        data_req = 4'b1101;
        #1;
        chk("rd_lag_1", 32'(request_data), 32'd1);
        tick();
        chk("rd_follow_0", 32'(request_data), 32'd0);

        // Watchdog on ch0: timeout after 100 BUSY cycles with a re-trigger
        sel_req = 4'b0001;
        tick();
        sel_req = 4'b0000;
        chk("to_sel_ch0", 32'(active_ch), 32'd0);
        chk("to_sel_ft", 32'(frame_trigger), 32'd0);
        tick();
        chk("to_start_ft", 32'(frame_trigger), 32'd1);
        chk("to_start_cnt", 32'(frame_count), 32'd4);
        hits_a = 0;
        hits_b = 0;
        for (int i = 0; i < 99; i++) begin
            tick();
            if (timeout_err) hits_a++;
            if (frame_trigger) hits_b++;
        end
        chk("to_early_err", 32'(hits_a), 32'd0);
        chk("to_early_ft", 32'(hits_b), 32'd0);
        tick();
        chk("to_err", 32'(timeout_err), 32'd1);
        chk("to_retrig_ft", 32'(frame_trigger), 32'd1);
        chk("to_retrig_cnt", 32'(frame_count), 32'd5);

        // write_frame_done in the expiry cycle wins: no timeout_err
        hits_a = 0;
        for (int i = 0; i < 99; i++) begin
            tick();
            if (timeout_err) hits_a++;
        end
        chk("to_err_width", 32'(hits_a), 32'd0);
        write_frame_done = 1'b1;
        tick();
        write_frame_done = 1'b0;
        chk("to_wfd_prio_err", 32'(timeout_err), 32'd0);
        chk("to_wfd_prio_ft", 32'(frame_trigger), 32'd1);
        chk("to_wfd_prio_cnt", 32'(frame_count), 32'd6);

        // Reset while write_start is in flight
        tick();
        black_output = 1'b1;
        tick();
        tick();
        black_output = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        hits_a = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (write_start) hits_a++;
        end
        chk("midrst_ws", 32'(hits_a), 32'd0);
        initial_done = 1'b0;
        rst_n = 1'b1;
        hits_a = 0;
        hits_b = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (frame_trigger) hits_a++;
            if (write_start) hits_b++;
        end
        chk("postrst_ft", 32'(hits_a), 32'd0);
        chk("postrst_ws", 32'(hits_b), 32'd0);
        chk("postrst_cnt", 32'(frame_count), 32'd0);

        // Channel 0 needs a fresh init_rise after reset
        initial_done = 1'b1;
        tick();
        tick();
        tick();
        chk("reinit_ft_early", 32'(frame_trigger), 32'd0);
        tick();
        chk("reinit_ft", 32'(frame_trigger), 32'd1);
        chk("reinit_cnt", 32'(frame_count), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
